// File: rtl/walk_timer_fsm.sv
// Crosswalk pedestrian-phase sequencer: WALK, flashing DON'T WALK, steady hold, then idle.
// Every output is registered from the next-state values, so the lamps change on the edge that moves the state.
module walk_timer_fsm #(
    parameter int unsigned FLASH_TICKS = 4,
    parameter int unsigned GAP_TICKS   = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic       walk_req_i,
    input  logic [3:0] dur_q_i,
    output logic       walk_o,
    output logic       dont_walk_o,
    output logic [3:0] count_o,
    output logic       done_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWalk,
        StFlash,
        StHold
    } state_e;

    localparam logic [3:0] FlashLoad = 4'(FLASH_TICKS);
    localparam logic [3:0] GapLoad   = 4'(GAP_TICKS);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       fph_q, fph_d;
    logic       done_d;

    logic       walk_d, dont_walk_d, busy_d;
    logic [3:0] count_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        fph_d   = fph_q;
        done_d  = 1'b0;

        // A request that arrives mid-cycle is remembered for the next walk phase.
        if (walk_req_i && (state_q != StIdle)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (walk_req_i || pend_q) begin
                    state_d = StWalk;
                    cnt_d   = (dur_q_i == 4'd0) ? 4'd1 : dur_q_i;
                    pend_d  = 1'b0;
                end
            end
            StWalk: begin
                if (tick_i) begin
                    if (cnt_q == 4'd1) begin
                        state_d = StFlash;
                        cnt_d   = FlashLoad;
                        fph_d   = 1'b1;
                    end else if (cnt_q > 4'd1) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StFlash: begin
                if (tick_i) begin
                    fph_d = ~fph_q;
                    if (cnt_q == 4'd1) begin
                        state_d = StHold;
                        cnt_d   = GapLoad;
                        done_d  = 1'b1;
                    end else if (cnt_q > 4'd1) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StHold: begin
                if (tick_i) begin
                    if (cnt_q == 4'd1) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else if (cnt_q > 4'd1) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        walk_d      = (state_d == StWalk);
        busy_d      = (state_d != StIdle);
        dont_walk_d = 1'b1;
        count_d     = 4'd0;
        unique case (state_d)
            StWalk: begin
                dont_walk_d = 1'b0;
                count_d     = cnt_d;
            end
            StFlash: begin
                dont_walk_d = fph_d;
                count_d     = cnt_d;
            end
            default: begin
                dont_walk_d = 1'b1;
                count_d     = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            fph_q       <= 1'b0;
            walk_o      <= 1'b0;
            dont_walk_o <= 1'b1;
            count_o     <= 4'd0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            fph_q       <= fph_d;
            walk_o      <= walk_d;
            dont_walk_o <= dont_walk_d;
            count_o     <= count_d;
            done_o      <= done_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_walk_timer_fsm.sv
// Directed bench for walk_timer_fsm: hand-computed lamp/count/busy/done vectors per tick.
module tb_walk_timer_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       walk_req;
    logic [3:0] dur_q;
    logic       walk;
    logic       dont_walk;
    logic [3:0] count;
    logic       done;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    walk_timer_fsm #(
        .FLASH_TICKS(4),
        .GAP_TICKS  (2)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .tick_i     (tick),
        .walk_req_i (walk_req),
        .dur_q_i    (dur_q),
        .walk_o     (walk),
        .dont_walk_o(dont_walk),
        .count_o    (count),
        .done_o     (done),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int w, input int dw, input int c,
                             input int b, input int dn);
        check({tag, ".walk"}, int'(walk), w);
        check({tag, ".dont_walk"}, int'(dont_walk), dw);
        check({tag, ".count"}, int'(count), c);
        check({tag, ".busy"}, int'(busy), b);
        check({tag, ".done"}, int'(done), dn);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int gap);
        repeat (gap) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic request();
        walk_req = 1'b1;
        step();
        walk_req = 1'b0;
    endtask

    // {walk, dont_walk, count, busy, done} after each tick of a dur_q=3 phase.
    int e2[9][5] = '{
        '{1, 0, 2, 1, 0},
        '{1, 0, 1, 1, 0},
        '{0, 1, 4, 1, 0},
        '{0, 0, 3, 1, 0},
        '{0, 1, 2, 1, 0},
        '{0, 0, 1, 1, 0},
        '{0, 1, 0, 1, 1},
        '{0, 1, 0, 1, 0},
        '{0, 1, 0, 0, 0}
    };

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        walk_req = 1'b0;
        dur_q    = 4'd0;
        step();
        step();
        reset = 1'b0;
        check_out("reset", 0, 1, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            tick = ~tick;
            step();
            check_out("idle_tick", 0, 1, 0, 0, 0);
        end
        tick = 1'b0;

        // Full phase with dur_q=3, tick every 4 clocks.
        dur_q = 4'd3;
        request();
        check_out("t2_req", 1, 0, 3, 1, 0);
        for (int i = 0; i < 9; i++) begin
            do_tick(3);
            check_out($sformatf("t2_tick%0d", i), e2[i][0], e2[i][1], e2[i][2], e2[i][3],
                      e2[i][4]);
            if (e2[i][4] == 1) begin
                step();
                check("t2_done_clr", int'(done), 0);
            end
        end

        // dur_q=0 loads 1; a tick coincident with the request is ignored.
        dur_q    = 4'd0;
        walk_req = 1'b1;
        tick     = 1'b1;
        step();
        walk_req = 1'b0;
        tick     = 1'b0;
        check_out("t3_req", 1, 0, 1, 1, 0);
        do_tick(2);
        check_out("t3_flash", 0, 1, 4, 1, 0);
        repeat (6) do_tick(1);
        check_out("t3_idle", 0, 1, 0, 0, 0);

        // Request during FLASH is replayed after HOLD via one IDLE clock.
        dur_q = 4'd5;
        request();
        check_out("t4_req", 1, 0, 5, 1, 0);
        repeat (5) do_tick(1);
        check_out("t4_flash", 0, 1, 4, 1, 0);
        do_tick(1);
        request();
        repeat (3) do_tick(1);
        check_out("t4_hold", 0, 1, 0, 1, 1);
        repeat (2) do_tick(1);
        check_out("t4_idle_gap", 0, 1, 0, 0, 0);
        step();
        check_out("t4_rewalk", 1, 0, 5, 1, 0);
        repeat (11) do_tick(0);
        check_out("t4_end", 0, 1, 0, 0, 0);
        repeat (3) step();
        check("t4_pend_clr", int'(busy), 0);

        // Reset mid-WALK wins over tick/walk_req and drops the pending request.
        dur_q = 4'd4;
        request();
        do_tick(1);
        request();
        do_tick(1);
        check_out("t5_pre", 1, 0, 2, 1, 0);
        reset    = 1'b1;
        tick     = 1'b1;
        walk_req = 1'b1;
        step();
        reset    = 1'b0;
        tick     = 1'b0;
        walk_req = 1'b0;
        check_out("t5_reset", 0, 1, 0, 0, 0);
        repeat (3) step();
        check("t5_pend_lost", int'(busy), 0);

        // dur_q is sampled only at WALK entry.
        dur_q = 4'd4;
        request();
        dur_q = 4'd9;
        check_out("t6_req", 1, 0, 4, 1, 0);
        repeat (3) do_tick(1);
        check_out("t6_last", 1, 0, 1, 1, 0);
        do_tick(1);
        check_out("t6_flash", 0, 1, 4, 1, 0);
        repeat (6) do_tick(1);
        check_out("t6_idle", 0, 1, 0, 0, 0);
        request();
        check_out("t6_new", 1, 0, 9, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/walk_timer_fsm.md
# walk_timer_fsm

Crosswalk pedestrian-phase sequencer that reads the walk duration held in the 4-bit duration register and runs it out. It sits downstream of that register: the register is written by the configuration path, and this block samples its `q` value when a walk phase starts. It then drives the WALK / flashing DON'T WALK / steady DON'T WALK signal heads and the countdown display. Time advances only on a one-cycle `tick` strobe from the shared prescaler.

## Interface
- `FLASH_TICKS`, 4: length of the flashing DON'T WALK phase, in ticks (1–15).
- `GAP_TICKS`, 2: length of the mandatory steady DON'T WALK hold after flashing, in ticks (1–15).
- `clk` input, 1: system clock. All state updates on its rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `tick` input, 1: one-cycle time-base strobe.
- `walk_req` input, 1: pedestrian request. Level-sampled each cycle.
- `dur_q` input, 4: walk duration in ticks, read from the duration register output.
- `walk` output, 1: WALK lamp.
- `dont_walk` output, 1: DON'T WALK lamp.
- `count` output, 4: countdown display value.
- `done` output, 1: one-cycle pulse when flashing ends.
- `busy` output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, WALK, FLASH, HOLD. The encoding is free. Every output is registered (Moore).
- Internal signals:
  - `cnt[3:0]`: phase counter.
  - `pend`: latched request.
  - `fph`: flash phase.
- `pend` is set by `walk_req`=1 in WALK, FLASH or HOLD. It is cleared on entry to WALK.
- IDLE:
  - `walk`=0, `dont_walk`=1, `count`=0.
  - If `walk_req` or `pend` is set, go to WALK and load `cnt` <= `dur_q`.
  - If `dur_q`==0, load 1 instead.
  - A `tick` in the same cycle is ignored.
- WALK:
  - `walk`=1, `dont_walk`=0, `count`=`cnt`.
  - On `tick`: if `cnt`==1, go to FLASH with `cnt` <= `FLASH_TICKS` and `fph` <= 1. Otherwise `cnt` <= `cnt`-1.
- FLASH:
  - `walk`=0, `dont_walk`=`fph`, `count`=`cnt`.
  - On `tick`: `fph` toggles.
  - On `tick` with `cnt`==1: go to HOLD with `cnt` <= `GAP_TICKS`, and pulse `done`=1 for the next cycle only.
  - Otherwise on `tick`: `cnt` <= `cnt`-1.
- HOLD:
  - `walk`=0, `dont_walk`=1, `count`=0.
  - On `tick` with `cnt`==1: go to IDLE. Otherwise on `tick`: `cnt` <= `cnt`-1.
  - If `pend`=1 on the return to IDLE, WALK is entered on the following cycle.
- `walk` and `dont_walk` are never both 1. Both may be 0, but only during the FLASH off-phase.
- `dur_q` is sampled only on the IDLE→WALK transition. Changes to it mid-phase have no effect.
- `busy` = (state != IDLE), registered.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, `pend`=0, `fph`=0.
  - Outputs: `walk`=0, `dont_walk`=1, `count`=0, `done`=0, `busy`=0.
  - `reset` overrides `tick` and `walk_req` in the same cycle. A reset mid-phase returns to IDLE on the next edge, and any pending request is lost.
- Request latency: with `walk_req` high at edge n in IDLE, `walk`=1 and `busy`=1 after edge n.
- WALK lasts exactly max(`dur_q`,1) ticks. FLASH lasts `FLASH_TICKS` ticks. HOLD lasts `GAP_TICKS` ticks.
- The minimum cycle from a request to the next possible WALK is (`dur_q`+`FLASH_TICKS`+`GAP_TICKS`) ticks + 1 clock.
- Back-to-back ticks (`tick` high on consecutive cycles) each count. Nothing depends on tick spacing.
- `done` is high for exactly one clock, coincident with the first HOLD cycle.
- `cnt` never wraps: a decrement only happens when `cnt`>1.

## Test plan
- Reset, then idle with `tick` toggling → `walk`=0, `dont_walk`=1, `count`=0, `busy`=0, and no state change.
- `dur_q`=3 with a 1-clock `walk_req`, `tick` every 4 clocks, default parameters:
  - `walk`=1 with `count` sequence 3, 2, 1.
  - Then FLASH: `count` 4, 3, 2, 1, with `dont_walk` 1, 0, 1, 0.
  - `done` pulses once.
  - HOLD lasts 2 ticks, then IDLE.
- `dur_q`=0 with a request → exactly 1 tick of WALK with `count`=1, then FLASH.
- `walk_req` pulsed during FLASH, `dur_q`=5 → after HOLD the block returns to IDLE for 1 clock, re-enters WALK with `count`=5, and `pend` clears.
- `reset` asserted in the middle of WALK (`count`=2) → next cycle: IDLE, `walk`=0, `dont_walk`=1, `count`=0. A pending request is discarded.
- `dur_q` changed from 4 to 9 during WALK → phase still lasts 4 ticks. The next request loads 9.
